// File: rtl/aes_pkg.sv
// Shared AES byte/state types, scheduler FSM encoding and GF(2^8) sbox math.
package aes_pkg;

   localparam int N_DEF     = 4;
   localparam int LANES_DEF = 4;

   typedef logic [7:0] byte_t;
   typedef byte_t [N_DEF-1:0][N_DEF-1:0] state_t;
   typedef byte_t [N_DEF-1:0] word_t;

   typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW} sched_state_e;

   localparam int ST_CYCLES = N_DEF * N_DEF / LANES_DEF;
   localparam int KW_CYCLES = (N_DEF + LANES_DEF - 1) / LANES_DEF;

   function automatic byte_t gf_mul(byte_t a, byte_t b);
      byte_t p;
      byte_t x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic byte_t rotl(byte_t a, int k);
      return byte_t'((a << k) | (a >> (8 - k)));
   endfunction

   // Inverse as a^254 by square-and-multiply (0 maps to 0), then the affine map.
   function automatic byte_t sbox_f(byte_t a);
      byte_t r;
      byte_t p;
      byte_t e;
      r = 8'h01;
      p = a;
      e = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward sbox, one byte in, one byte out.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   assign y_o = sbox_f(a_i);

endmodule

// File: rtl/sub_bytes_scheduler.sv
// Shares LANES sboxes between state SubBytes and key-word SubWord jobs.
// Define SUB_BYTES_SCHED_KEY_PRIO_EN for fixed key-word priority on ties.
module sub_bytes_scheduler
   import aes_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LANES = LANES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [N*N*8-1:0] st_in,
   output logic [N*N*8-1:0] st_out,
   output logic             st_done,
   input  logic             kw_valid,
   output logic             kw_ready,
   input  logic [N*8-1:0]   kw_in,
   output logic [N*8-1:0]   kw_out,
   output logic             kw_done
);

   localparam int NB = N * N;
   localparam int CW = $clog2(NB + LANES + 1);

   sched_state_e          state_q, state_d;
   logic [CW-1:0]         k_q;
   logic [NB*8-1:0]       job_q, stg_q, stg_d, st_out_q;
   logic [N*8-1:0]        kw_out_q;
   logic                  st_done_q, kw_done_q;
   logic                  idle, running, last, kw_prio, st_acc, kw_acc;
   int                    lim;
   logic [LANES-1:0][7:0] lane_in, lane_out;

`ifdef SUB_BYTES_SCHED_KEY_PRIO_EN
   assign kw_prio = 1'b1;
`else
   logic rr_q;
   // Pointer favours whichever requester was not served last.
   always_ff @(posedge clk) begin
      if (rst)         rr_q <= 1'b1;
      else if (st_acc) rr_q <= 1'b1;
      else if (kw_acc) rr_q <= 1'b0;
   end
   assign kw_prio = rr_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:           if (st_acc) state_d = RUN_ST;
                         else if (kw_acc) state_d = RUN_KW;
         RUN_ST, RUN_KW: if (last) state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_comb begin
      idle     = (state_q == IDLE);
      running  = !idle;
      st_ready = !rst && idle && (kw_valid ? (st_valid && !kw_prio) : 1'b1);
      kw_ready = !rst && idle && (st_valid ? (kw_valid && kw_prio) : 1'b1);
      lim      = (state_q == RUN_KW) ? N : NB;
      last     = running && (int'(k_q) + LANES >= lim);
   end

   assign st_acc = st_valid && st_ready;
   assign kw_acc = kw_valid && kw_ready;

   // Lanes past the end of the job see a constant zero.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_in[l] = 8'h00;
         if (int'(k_q) + l < lim) lane_in[l] = job_q[(int'(k_q) + l)*8 +: 8];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      aes_sbox u_sbox (
         .a_i (lane_in[g]),
         .y_o (lane_out[g])
      );
   end

   always_comb begin
      stg_d = stg_q;
      if (running) begin
         for (int l = 0; l < LANES; l++) begin
            if (int'(k_q) + l < lim) stg_d[(int'(k_q) + l)*8 +: 8] = lane_out[l];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q       <= '0;
         job_q     <= '0;
         stg_q     <= '0;
         st_out_q  <= '0;
         kw_out_q  <= '0;
         st_done_q <= 1'b0;
         kw_done_q <= 1'b0;
      end else begin
         st_done_q <= 1'b0;
         kw_done_q <= 1'b0;
         if (st_acc) begin
            job_q <= st_in;
            k_q   <= '0;
         end else if (kw_acc) begin
            job_q <= (NB*8)'(kw_in);
            k_q   <= '0;
         end else if (running) begin
            k_q   <= k_q + CW'(LANES);
            stg_q <= stg_d;
            if (last && state_q == RUN_ST) begin
               st_out_q  <= stg_d;
               st_done_q <= 1'b1;
            end
            if (last && state_q == RUN_KW) begin
               kw_out_q  <= stg_d[N*8-1:0];
               kw_done_q <= 1'b1;
            end
         end
      end
   end

   assign st_out  = st_out_q;
   assign kw_out  = kw_out_q;
   assign st_done = st_done_q;
   assign kw_done = kw_done_q;

endmodule
